// File: rtl/rv_decode_pkg.sv
// RV32I decode types shared by the instruction decoder slice: format enum,
// opcode constants, decoded-word struct and the pure decode function.
package rv_decode_pkg;

  typedef enum logic [2:0] {
    TYPE_R       = 3'd0,
    TYPE_I       = 3'd1,
    TYPE_S       = 3'd2,
    TYPE_B       = 3'd3,
    TYPE_U       = 3'd4,
    TYPE_J       = 3'd5,
    TYPE_ILLEGAL = 3'd6
  } instr_type_e;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  typedef struct packed {
    instr_type_e        itype;
    logic [6:0]         opcode;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic signed [31:0] imm;
  } dec_instr_t;

  function automatic dec_instr_t decode_rv32i(input logic [31:0] instr);
    dec_instr_t d;
    d.opcode = instr[6:0];
    d.rd     = instr[11:7];
    d.rs1    = instr[19:15];
    d.rs2    = instr[24:20];
    d.funct3 = instr[14:12];
    d.funct7 = instr[31:25];
    d.itype  = TYPE_ILLEGAL;
    d.imm    = '0;
    // Compressed encodings (instr[1:0] != 2'b11) never match a listed opcode.
    case (instr[6:0])
      OPC_OP:
        d.itype = (instr[31:25] == 7'b0000000 || instr[31:25] == 7'b0100000)
                  ? TYPE_R : TYPE_ILLEGAL;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: begin
        d.itype = TYPE_I;
        d.imm   = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        d.itype = TYPE_S;
        d.imm   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        d.itype = TYPE_B;
        d.imm   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        d.itype = TYPE_U;
        d.imm   = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        d.itype = TYPE_J;
        d.imm   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rv_instr_fifo.sv
// Synchronous FIFO for raw instruction words; storage is not reset, only
// pointers and occupancy are.
module rv_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rv_instr_decoder.sv
// RV32I instruction decoder: buffered input, registered decoded output with
// valid/ready, and saturating retired/illegal counters.
module rv_instr_decoder
  import rv_decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       rv32i,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dec_valid,
  input  logic              dec_ready,
  output instr_type_e       dec_type,
  output logic [6:0]        dec_opcode,
  output logic [4:0]        dec_rd,
  output logic [4:0]        dec_rs1,
  output logic [4:0]        dec_rs2,
  output logic [2:0]        dec_funct3,
  output logic [6:0]        dec_funct7,
  output logic [31:0]       dec_imm,
  output logic              dec_illegal,
  output logic [CNT_W-1:0]  cnt_total,
  output logic [CNT_W-1:0]  cnt_illegal
);

  localparam int AW = $clog2(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [31:0]   head_p0;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;
  logic          push_p0;
  logic          load_p1;
  logic          hs_p1;
  logic          vld_p1;
  dec_instr_t    dec_p1;

  assign in_ready = (fifo_count != (AW+1)'(DEPTH));
  assign push_p0  = in_valid && !fifo_full;
  assign load_p1  = (!vld_p1 || dec_ready) && !fifo_empty;
  assign hs_p1    = vld_p1 && dec_ready;

  rv_instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_p0),
    .pop   (load_p1),
    .wdata (rv32i),
    .rdata (head_p0),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---- p0 -> p1: decode FIFO head into the output register ----
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      dec_p1      <= '0;
      cnt_total   <= '0;
      cnt_illegal <= '0;
    end else begin
      if (load_p1) begin
        dec_p1 <= decode_rv32i(head_p0);
        vld_p1 <= 1'b1;
      end else if (hs_p1) begin
        vld_p1 <= 1'b0;
      end
      if (hs_p1) begin
        cnt_total <= sat_inc(cnt_total);
        if (dec_p1.itype == TYPE_ILLEGAL) cnt_illegal <= sat_inc(cnt_illegal);
      end
    end
  end

  assign dec_valid   = vld_p1;
  assign dec_type    = dec_p1.itype;
  assign dec_opcode  = dec_p1.opcode;
  assign dec_rd      = dec_p1.rd;
  assign dec_rs1     = dec_p1.rs1;
  assign dec_rs2     = dec_p1.rs2;
  assign dec_funct3  = dec_p1.funct3;
  assign dec_funct7  = dec_p1.funct7;
  assign dec_imm     = dec_p1.imm;
  assign dec_illegal = (dec_p1.itype == TYPE_ILLEGAL);

endmodule

// File: tb/tb_rv_instr_decoder.sv
// Directed bench for rv_instr_decoder: decode formats, latency, backpressure,
// back-to-back streaming and mid-stream reset.
module tb_rv_instr_decoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
                         T_U = 3'd4, T_J = 3'd5, T_ILL = 3'd6;

  logic             clock = 1'b0;
  logic             reset;
  logic [31:0]      rv32i;
  logic             in_valid;
  logic             in_ready;
  logic             dec_valid;
  logic             dec_ready;
  logic [2:0]       dec_type;
  logic [6:0]       dec_opcode;
  logic [4:0]       dec_rd, dec_rs1, dec_rs2;
  logic [2:0]       dec_funct3;
  logic [6:0]       dec_funct7;
  logic [31:0]      dec_imm;
  logic             dec_illegal;
  logic [CNT_W-1:0] cnt_total, cnt_illegal;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  rv_instr_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .rv32i       (rv32i),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_type    (dec_type),
    .dec_opcode  (dec_opcode),
    .dec_rd      (dec_rd),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_funct3  (dec_funct3),
    .dec_funct7  (dec_funct7),
    .dec_imm     (dec_imm),
    .dec_illegal (dec_illegal),
    .cnt_total   (cnt_total),
    .cnt_illegal (cnt_illegal)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // addi x1,x0,v : immediate v, used to tag stream words
  function automatic logic [31:0] addi_w(input int v);
    return {v[11:0], 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  // Push one word into an idle decoder, check latency and the decoded type/imm.
  task automatic send_chk(input string tag, input logic [31:0] w,
                          input logic [2:0] et, input logic [31:0] eimm);
    dec_ready = 1'b1;
    rv32i     = w;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    check_eq({tag, "_lat0"}, {31'd0, dec_valid}, 32'd0);
    tick();
    check_eq({tag, "_vld"}, {31'd0, dec_valid}, 32'd1);
    check_eq({tag, "_type"}, {29'd0, dec_type}, {29'd0, et});
    check_eq({tag, "_imm"}, dec_imm, eimm);
    check_eq({tag, "_ill"}, {31'd0, dec_illegal}, {31'd0, (et == T_ILL)});
    tick();
  endtask

  int acc, pi, oi, cyc;
  logic rdy;

  initial begin
    reset = 1'b1; in_valid = 1'b0; dec_ready = 1'b0; rv32i = '0;
    tick(); tick();
    reset = 1'b0;
    check_eq("rst_vld", {31'd0, dec_valid}, 32'd0);
    check_eq("rst_rdy", {31'd0, in_ready}, 32'd1);
    check_eq("rst_tot", {16'd0, cnt_total}, 32'd0);
    check_eq("rst_ill", {16'd0, cnt_illegal}, 32'd0);
    check_eq("rst_imm", dec_imm, 32'd0);
    check_eq("rst_rd", {27'd0, dec_rd}, 32'd0);

    // addi x5,x6,10 with field checks while it sits in the output register
    dec_ready = 1'b1; rv32i = 32'h00A30293; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("addi_lat0", {31'd0, dec_valid}, 32'd0);
    tick();
    check_eq("addi_vld", {31'd0, dec_valid}, 32'd1);
    check_eq("addi_type", {29'd0, dec_type}, {29'd0, T_I});
    check_eq("addi_rd", {27'd0, dec_rd}, 32'd5);
    check_eq("addi_rs1", {27'd0, dec_rs1}, 32'd6);
    check_eq("addi_imm", dec_imm, 32'h0000000A);
    check_eq("addi_opc", {25'd0, dec_opcode}, 32'h13);
    check_eq("addi_tot0", {16'd0, cnt_total}, 32'd0);
    tick();
    check_eq("addi_tot1", {16'd0, cnt_total}, 32'd1);
    check_eq("addi_vld0", {31'd0, dec_valid}, 32'd0);

    // bne x4,x5,-28
    dec_ready = 1'b1; rv32i = 32'hFE5212E3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check_eq("bne_type", {29'd0, dec_type}, {29'd0, T_B});
    check_eq("bne_rs1", {27'd0, dec_rs1}, 32'd4);
    check_eq("bne_rs2", {27'd0, dec_rs2}, 32'd5);
    check_eq("bne_f3", {29'd0, dec_funct3}, 32'd1);
    check_eq("bne_imm", dec_imm, 32'hFFFFFFE4);
    tick();

    send_chk("sw_pos", 32'h00512423, T_S, 32'h00000008);
    send_chk("sw_neg", 32'hFE512E23, T_S, 32'hFFFFFFFC);
    send_chk("lui",    32'h123450B7, T_U, 32'h12345000);
    send_chk("jal",    32'hFFDFF06F, T_J, 32'hFFFFFFFC);
    send_chk("lw_neg", 32'hFFF12083, T_I, 32'hFFFFFFFF);
    send_chk("add",    32'h002081B3, T_R, 32'h00000000);
    send_chk("sub",    32'h402081B3, T_R, 32'h00000000);
    send_chk("mul",    32'h022081B3, T_ILL, 32'h00000000);
    check_eq("dec_ill_cnt", {16'd0, cnt_illegal}, 32'd1);
    check_eq("dec_tot_cnt", {16'd0, cnt_total}, 32'd10);

    // Fresh counters for the illegal-word pair
    reset = 1'b1; tick(); reset = 1'b0;
    send_chk("ones",  32'hFFFFFFFF, T_ILL, 32'h0);
    send_chk("zeros", 32'h00000000, T_ILL, 32'h0);
    check_eq("ill_cnt", {16'd0, cnt_illegal}, 32'd2);
    check_eq("ill_tot", {16'd0, cnt_total}, 32'd2);

    // Backpressure: DEPTH words in the FIFO plus one in the output register
    dec_ready = 1'b0; acc = 0;
    for (int c = 0; c < 20 && in_ready; c++) begin
      rv32i = addi_w(acc + 1); in_valid = 1'b1;
      tick();
      acc++;
    end
    check_eq("bp_accepts", acc, DEPTH + 1);
    rv32i = addi_w(99); in_valid = 1'b1;
    tick(); tick();
    check_eq("bp_rdy_low", {31'd0, in_ready}, 32'd0);
    check_eq("bp_hold_vld", {31'd0, dec_valid}, 32'd1);
    check_eq("bp_hold_imm", dec_imm, 32'd1);
    in_valid = 1'b0;
    dec_ready = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      check_eq($sformatf("bp_out%0d_vld", k), {31'd0, dec_valid}, 32'd1);
      check_eq($sformatf("bp_out%0d_imm", k), dec_imm, k + 1);
      tick();
    end
    check_eq("bp_drained", {31'd0, dec_valid}, 32'd0);
    check_eq("bp_rdy_back", {31'd0, in_ready}, 32'd1);

    // Prefill to DEPTH-1 in the FIFO, then stream with push and pop each cycle
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rv32i = addi_w(100 + i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check_eq("b2b_pre_rdy", {31'd0, in_ready}, 32'd1);
    dec_ready = 1'b1; pi = 4; oi = 0; cyc = 0;
    while (oi < 12 && cyc < 50) begin
      if (dec_valid) begin
        check_eq($sformatf("b2b_out%0d", oi), dec_imm, 100 + oi);
        oi++;
      end
      if (pi < 12) begin
        check_eq($sformatf("b2b_rdy%0d", pi), {31'd0, in_ready}, 32'd1);
        rv32i = addi_w(100 + pi); in_valid = 1'b1; rdy = in_ready;
      end else begin
        in_valid = 1'b0; rdy = 1'b0;
      end
      tick();
      if (in_valid && rdy) pi++;
      cyc++;
    end
    in_valid = 1'b0;
    check_eq("b2b_count", oi, 12);
    check_eq("b2b_cycles", cyc, 12);
    check_eq("stat_tot", {16'd0, cnt_total}, 32'd19);
    check_eq("stat_ill", {16'd0, cnt_illegal}, 32'd2);

    // Reset with 3 words buffered and a word held in the output register
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rv32i = addi_w(200 + i); in_valid = 1'b1;
      tick();
    end
    check_eq("mid_vld", {31'd0, dec_valid}, 32'd1);
    reset = 1'b1; dec_ready = 1'b1; rv32i = addi_w(300); in_valid = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    check_eq("mid_rst_vld", {31'd0, dec_valid}, 32'd0);
    check_eq("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
    check_eq("mid_rst_tot", {16'd0, cnt_total}, 32'd0);
    check_eq("mid_rst_ill", {16'd0, cnt_illegal}, 32'd0);
    tick();
    check_eq("mid_rst_empty", {31'd0, dec_valid}, 32'd0);
    send_chk("post_rst", 32'h00A30293, T_I, 32'h0000000A);
    check_eq("post_rst_tot", {16'd0, cnt_total}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rv_instr_decoder.md
Name: rv_instr_decoder

Overview:
- Downstream consumer of the generated RV32I instruction stream; receives raw 32-bit instruction words from the generator driver side.
- Buffers words in a small FIFO and decodes each into format type, register fields and sign-extended immediate.
- Presents decoded words on a registered valid/ready output to the checker/scoreboard.
- Keeps saturating counts of retired (consumed) and illegal instructions.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- rv32i  in  32  raw instruction word.
- in_valid  in  1  rv32i holds a valid word.
- in_ready  out  1  FIFO can accept; equals !full.
- dec_valid  out  1  decoded output register holds a word.
- dec_ready  in  1  consumer accepts the decoded word.
- dec_type  out  3  instr_type_e: R, I, S, B, U, J, ILLEGAL.
- dec_opcode  out  7  instr[6:0].
- dec_rd, dec_rs1, dec_rs2  out  5 each  instr[11:7], instr[19:15], instr[24:20]; raw, always driven.
- dec_funct3  out  3  instr[14:12].
- dec_funct7  out  7  instr[31:25].
- dec_imm  out  32  sign-extended immediate per format; 0 for R and ILLEGAL.
- dec_illegal  out  1  dec_type == ILLEGAL.
- cnt_total  out  CNT_W  decoded words consumed.
- cnt_illegal  out  CNT_W  illegal words consumed.

Behaviour:
- Reset (synchronous, sampled at posedge): FIFO empty, wr/rd pointers 0, dec_valid=0, all dec_* fields 0, cnt_total=0, cnt_illegal=0, in_ready=1 on the next cycle.
- Input handshake: a word is pushed when in_valid && in_ready at posedge.
  - in_ready = !full, combinational from the occupancy count.
  - No write-through when full; a word offered while full is held off, not dropped.
- Output stage:
  - The output register loads the FIFO head, decoded, when (!dec_valid || dec_ready) && !empty.
  - dec_valid deasserts after a dec_valid && dec_ready handshake when the FIFO is empty.
- Latency:
  - A word accepted at edge N, with an empty FIFO and a free output register, is loaded at edge N+1. dec_valid is high in the cycle after N+1.
  - No combinational path from rv32i to dec_*.
- Throughput: 1 word/cycle sustained when dec_ready is held high.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - Pointers wrap modulo DEPTH.
  - Full is asserted only when occupancy == DEPTH.
- Backpressure: while dec_valid && !dec_ready, all dec_* outputs hold stable and the FIFO keeps filling until full.
- Decode, on instr[6:0]:
  - 0110011 → R. ILLEGAL if funct7 is not 0000000 or 0100000.
  - 0010011, 0000011, 1100111, 1110011, 0001111 → I. imm = sext(instr[31:20]).
  - 0100011 → S. imm = sext({instr[31:25], instr[11:7]}).
  - 1100011 → B. imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 0110111, 0010111 → U. imm = {instr[31:12], 12'b0}.
  - 1101111 → J. imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Any other opcode, including instr[1:0] != 2'b11 → ILLEGAL. imm = 0.
- Counters:
  - On each output handshake, cnt_total += 1.
  - cnt_illegal += 1 if dec_illegal.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset mid-operation: FIFO contents are discarded, any in-flight output word is lost, and counters are cleared. No handshake is honoured on the reset edge.

Decomposition:
- Package rv_decode_pkg:
  - instr_type_e enum (3-bit).
  - OPC_* opcode localparams.
  - dec_instr_t packed struct (type, fields, imm).
  - Function decode_rv32i(logic [31:0]) returning dec_instr_t.
- Sub-module rv_instr_fifo: synchronous FIFO (DEPTH, WIDTH=32) with push/pop/full/empty/count.
- The top holds the output register and the counters.

Test Plan:
- Reset, then push 0x00A30293 (addi x5,x6,10) with dec_ready=1 → two cycles later: dec_type=I, rd=5, rs1=6, imm=0x0000000A, cnt_total=1 after the handshake.
- Push 0xFE5212E3 (bne x4,x5,-28) → dec_type=B, rs1=4, rs2=5, imm=0xFFFFFFE4.
- Push 0xFFFFFFFF and 0x00000000 → both ILLEGAL with imm=0; cnt_illegal=2, cnt_total=2.
- Hold dec_ready=0 and stream DEPTH+1 words → in_ready drops after DEPTH+1 accepts (DEPTH in the FIFO plus 1 in the output register). dec_* stays stable. Release dec_ready and all words emerge in order with no loss.
- Back-to-back stream with dec_ready=1 and simultaneous push/pop at full-1 → one output per cycle, pointers wrap correctly, order preserved.
- Assert reset with 3 words buffered and dec_valid=1 → next cycle dec_valid=0, in_ready=1, counters 0; the next pushed word decodes correctly.
